// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared widths, ALU opcodes and issue FSM state encoding
package alu_issue_pkg;
  localparam int REG_WIDTH = 16;
  localparam int ALU_OP_WIDTH = 4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOT = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LSL = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LSR = 4'd7;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;
endpackage

// File: rtl/alu_issue_reg_file.sv
// alu_issue_reg_file: register file with two operand ports, a debug port and one write port; r0 is hardwired zero
module alu_issue_reg_file #(
  parameter int NUM_REGS = 8,
  parameter int REG_W = 16,
  parameter int IDX_W = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] ra,
  input  logic [IDX_W-1:0] rb,
  input  logic [IDX_W-1:0] rdbg,
  output logic [REG_W-1:0] da,
  output logic [REG_W-1:0] db,
  output logic [REG_W-1:0] ddbg,
  input  logic             we,
  input  logic [IDX_W-1:0] wa,
  input  logic [REG_W-1:0] wd
);
  logic [REG_W-1:0] regs [NUM_REGS];
  assign da = ra == '0 ? '0 : regs[ra];
  assign db = rb == '0 ? '0 : regs[rb];
  assign ddbg = rdbg == '0 ? '0 : regs[rdbg];
  // storage; writes to r0 are discarded so it stays zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (we && wa != '0)
      regs[wa] <= wd;
endmodule

// File: rtl/alu_issue.sv
// alu_issue: valid/ready issue and writeback front end driving an external combinational ALU
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int REG_W = REG_WIDTH,
  parameter int OP_W = ALU_OP_WIDTH,
  parameter int IDX_W = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [IDX_W-1:0] in_rs_idx,
  input  logic [IDX_W-1:0] in_rt_idx,
  input  logic [IDX_W-1:0] in_rd_idx,
  input  logic             in_use_imm,
  input  logic [REG_W-1:0] in_imm,
  output logic [OP_W-1:0]  alu_op,
  output logic [REG_W-1:0] alu_rs,
  output logic [REG_W-1:0] alu_rt,
  input  logic [REG_W-1:0] alu_rd,
  output logic             wb_valid,
  output logic [IDX_W-1:0] wb_idx,
  output logic [REG_W-1:0] wb_data,
  output logic             zero_flag,
  output logic             busy,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [REG_W-1:0] dbg_data
);
  state_t state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [IDX_W-1:0] rs_q, rt_q, rd_q;
  logic use_imm_q;
  logic [REG_W-1:0] imm_q, result_q, rs_val, rt_val;
  logic accept;
  assign in_ready = state_q == IDLE;
  assign accept = in_valid && in_ready;
  assign busy = state_q != IDLE;
  assign wb_valid = state_q == WB;
  assign wb_idx = rd_q;
  assign wb_data = result_q;
  alu_issue_reg_file #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .IDX_W(IDX_W)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ra(rs_q), .rb(rt_q), .rdbg(dbg_idx),
    .da(rs_val), .db(rt_val), .ddbg(dbg_data),
    .we(wb_valid), .wa(rd_q), .wd(result_q)
  );
  // one cycle per state once an instruction is accepted
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (accept ? READ : IDLE) :
              state_q == READ ? EXEC :
              state_q == EXEC ? WB : IDLE;
  end
  // latch the instruction, read operands, capture the result, update the zero flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
      use_imm_q <= 1'b0;
      imm_q <= '0;
      result_q <= '0;
      alu_op <= OP_W'(ALU_OP_ADD);
      alu_rs <= '0;
      alu_rt <= '0;
      zero_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= in_op;
        rs_q <= in_rs_idx;
        rt_q <= in_rt_idx;
        rd_q <= in_rd_idx;
        use_imm_q <= in_use_imm;
        imm_q <= in_imm;
      end
      if (state_q == READ) begin
        alu_op <= op_q;
        alu_rs <= rs_val;
        alu_rt <= use_imm_q ? imm_q : rt_val;
      end
      if (state_q == EXEC) result_q <= alu_rd;
      if (state_q == WB) zero_flag <= result_q == '0;
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized and directed checks of alu_issue against an architectural register model
module tb_alu_issue;
  import alu_issue_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_op = '0;
  logic [2:0] in_rs_idx = '0, in_rt_idx = '0, in_rd_idx = '0, dbg_idx = '0;
  logic in_use_imm = 1'b0;
  logic [15:0] in_imm = '0;
  logic [3:0] alu_op;
  logic [15:0] alu_rs, alu_rt, alu_rd, wb_data, dbg_data;
  logic wb_valid, zero_flag, busy;
  logic [2:0] wb_idx;
  logic [15:0] model [8];
  logic model_zf;
  int vectors = 0;
  int miscompares = 0;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .alu_op(alu_op), .alu_rs(alu_rs),
    .alu_rt(alu_rt), .alu_rd(alu_rd), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .wb_data(wb_data), .zero_flag(zero_flag), .busy(busy), .dbg_idx(dbg_idx),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      ALU_OP_XOR: return a ^ b;
      ALU_OP_NOT: return ~a;
      ALU_OP_LSL: return a << b[3:0];
      ALU_OP_LSR: return a >> b[3:0];
      default:    return a ^ ~b;
    endcase
  endfunction

  // stand-in for the external combinational ALU
  always_comb alu_rd = alu_fn(alu_op, alu_rs, alu_rt);

  task automatic run_instr(input logic [3:0] op, input int rd, input int rs, input int rt,
                           input logic ui, input logic [15:0] imm, input logic hold);
    logic [15:0] a, b, r;
    a = rs == 0 ? 16'h0 : model[rs];
    b = ui ? imm : (rt == 0 ? 16'h0 : model[rt]);
    r = alu_fn(op, a, b);
    @(negedge clk);
    in_op = op; in_rd_idx = 3'(rd); in_rs_idx = 3'(rs); in_rt_idx = 3'(rt);
    in_use_imm = ui; in_imm = imm; in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_idle: got %b want 1", in_ready); end
    @(posedge clk); #1;
    if (hold) begin in_op = op ^ 4'h3; in_rd_idx = 3'(rd) ^ 3'd1; in_imm = ~imm; end
    else in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      vectors += 3;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ready_busy c%0d: got %b want 0", c, in_ready); end
      if (busy !== 1'b1) begin miscompares++; $display("FAIL busy c%0d: got %b want 1", c, busy); end
      if (wb_valid !== (c == 2)) begin miscompares++; $display("FAIL wb_valid c%0d: got %b want %b", c, wb_valid, c == 2); end
      if (c == 1) begin
        vectors += 3;
        if (alu_op !== op) begin miscompares++; $display("FAIL alu_op: got %h want %h", alu_op, op); end
        if (alu_rs !== a) begin miscompares++; $display("FAIL alu_rs: got %h want %h", alu_rs, a); end
        if (alu_rt !== b) begin miscompares++; $display("FAIL alu_rt: got %h want %h", alu_rt, b); end
      end
      if (c == 2) begin
        in_valid = 1'b0;
        vectors += 2;
        if (wb_idx !== 3'(rd)) begin miscompares++; $display("FAIL wb_idx: got %0d want %0d", wb_idx, rd); end
        if (wb_data !== r) begin miscompares++; $display("FAIL wb_data: got %h want %h", wb_data, r); end
      end
    end
    if (rd != 0) model[rd] = r;
    model_zf = r == 16'h0;
    dbg_idx = 3'(rd);
    @(posedge clk); #1;
    vectors += 4;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after: got %b want 1", in_ready); end
    if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL wb_pulse_len: got %b want 0", wb_valid); end
    if (zero_flag !== model_zf) begin miscompares++; $display("FAIL zero_flag: got %b want %b", zero_flag, model_zf); end
    if (dbg_data !== (rd == 0 ? 16'h0 : model[rd])) begin
      miscompares++; $display("FAIL dbg_rd r%0d: got %h want %h", rd, dbg_data, rd == 0 ? 16'h0 : model[rd]);
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_idx = 3'(i);
      #1;
      vectors++;
      if (dbg_data !== model[i]) begin miscompares++; $display("FAIL %s r%0d: got %h want %h", tag, i, dbg_data, model[i]); end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    model_zf = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors += 8;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
    if (wb_idx !== 3'd0) begin miscompares++; $display("FAIL rst_wb_idx: got %0d want 0", wb_idx); end
    if (wb_data !== 16'h0) begin miscompares++; $display("FAIL rst_wb_data: got %h want 0", wb_data); end
    if (zero_flag !== 1'b0) begin miscompares++; $display("FAIL rst_zero_flag: got %b want 0", zero_flag); end
    if (alu_op !== ALU_OP_ADD) begin miscompares++; $display("FAIL rst_alu_op: got %h want %h", alu_op, ALU_OP_ADD); end
    if ({alu_rs, alu_rt} !== 32'h0) begin miscompares++; $display("FAIL rst_alu_operands: got %h want 0", {alu_rs, alu_rt}); end
    check_all_regs("rst_reg");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    run_instr(ALU_OP_ADD, 1, 0, 0, 1'b1, 16'd2, 1'b0);
    run_instr(ALU_OP_ADD, 2, 1, 0, 1'b1, 16'd3, 1'b0);
    run_instr(ALU_OP_LSL, 3, 1, 2, 1'b0, 16'hBEEF, 1'b0);
    run_instr(ALU_OP_AND, 4, 1, 0, 1'b0, 16'h1234, 1'b0);
    run_instr(ALU_OP_NOT, 5, 1, 0, 1'b0, 16'h0, 1'b0);
    run_instr(ALU_OP_ADD, 0, 1, 0, 1'b1, 16'd7, 1'b0);
    check_all_regs("dir_reg");
  endtask

  task automatic test_back_to_back_hold;
    run_instr(ALU_OP_SUB, 7, 3, 2, 1'b0, 16'h0, 1'b1);
    run_instr(ALU_OP_XOR, 6, 7, 0, 1'b1, 16'h0F0F, 1'b1);
    check_all_regs("hold_reg");
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++)
      run_instr(4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), 1'($urandom), 16'($urandom), 1'($urandom));
    check_all_regs("rand_reg");
  endtask

  task automatic test_reset_mid;
    run_instr(ALU_OP_ADD, 1, 0, 0, 1'b1, 16'h0055, 1'b0);
    @(negedge clk);
    in_op = ALU_OP_ADD; in_rd_idx = 3'd6; in_rs_idx = 3'd1; in_use_imm = 1'b1; in_imm = 16'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    #1;
    vectors += 3;
    if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_wb_valid: got %b want 0", wb_valid); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    if (alu_op !== ALU_OP_ADD) begin miscompares++; $display("FAIL midrst_alu_op: got %h want %h", alu_op, ALU_OP_ADD); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      vectors += 2;
      if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_no_wb c%0d: got %b want 0", c, wb_valid); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_idle c%0d: got %b want 0", c, busy); end
    end
    check_all_regs("midrst_reg");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back_hold;
    test_random;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
